// File: rtl/imem_low_load_controller_pkg.sv
// Shared types and constants for the low instruction-memory load controller.
// Widths, legal burst bounds and the controller state encoding live here.
package imem_low_load_controller_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 2 ** ADDR_W;

   // WORD_COUNT is one bit wider than an address so a full-depth burst fits
   localparam logic [ADDR_W:0] WORD_COUNT_MIN = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0] WORD_COUNT_MAX = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      BOOT,
      IDLE,
      LOAD,
      FLUSH
   } loadState_e;

endpackage

// File: rtl/imem_low_load_controller_read_arbiter.sv
// Shares the register file's single read port between CPU fetch and debug
// readback; debug only wins while the controller idles and the CPU is stopped.
module imem_read_arbiter
   import imem_low_load_controller_pkg::*;
(
   input  logic              cpuRun_i,
   input  logic              isIdle_i,
   input  logic              dbgReq_i,
   input  logic [ADDR_W-1:0] dbgAddr_i,
   input  logic [ADDR_W-1:0] pcAddr_i,
   output logic              grant_o,
   output logic [ADDR_W-1:0] readSel_o
);

   always_comb begin
      grant_o   = dbgReq_i & ~cpuRun_i & isIdle_i;
      readSel_o = grant_o ? dbgAddr_i : pcAddr_i;
   end

endmodule

// File: rtl/imem_low_load_controller.sv
// Streams a burst of words into the low 16-slot instruction register file,
// holding the CPU for the duration and keeping the BIOS-capture edge write-free.
module imem_low_load_controller
   import imem_low_load_controller_pkg::*;
(
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              START,
   input  logic [ADDR_W-1:0] BASE_ADDR,
   input  logic [ADDR_W:0]   WORD_COUNT,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              DATA_VALID,
   output logic              DATA_READY,
   output logic              WRITE_ENABLE,
   output logic [ADDR_W-1:0] WRITE_SELECT,
   output logic [DATA_W-1:0] IMEM_INPUT,
   input  logic              CPU_RUN,
   input  logic [ADDR_W-1:0] PC_ADDR,
   input  logic              DBG_READ_REQ,
   input  logic [ADDR_W-1:0] DBG_READ_ADDR,
   output logic              DBG_READ_GRANT,
   output logic [ADDR_W-1:0] READ_SELECT,
   output logic              CPU_HALT,
   output logic              BUSY,
   output logic              DONE,
   output logic              CMD_ERROR
);

   loadState_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   remaining_q, remaining_d;
   logic              writeEn_q, writeEn_d;
   logic [ADDR_W-1:0] writeSel_q, writeSel_d;
   logic [DATA_W-1:0] writeData_q, writeData_d;
   logic              cpuHalt_q, cpuHalt_d;
   logic              busy_q, busy_d;
   logic              cmdError_q, cmdError_d;
   logic              countLegal;
   logic              handshake;

   assign countLegal = (WORD_COUNT >= WORD_COUNT_MIN) && (WORD_COUNT <= WORD_COUNT_MAX);
   assign handshake  = DATA_VALID && DATA_READY;

   // Ready is a pure state decode, so it drops the moment FLUSH is entered
   always_comb begin
      DATA_READY = (state_q == LOAD);
      DONE       = (state_q == FLUSH);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      writeEn_d   = 1'b0;
      writeSel_d  = writeSel_q;
      writeData_d = writeData_q;
      cmdError_d  = 1'b0;

      case (state_q)
         BOOT: begin
            state_d = IDLE;
         end
         IDLE: begin
            if (START) begin
               if (countLegal) begin
                  addr_d      = BASE_ADDR;
                  remaining_d = WORD_COUNT;
                  state_d     = LOAD;
               end else begin
                  cmdError_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (handshake) begin
               writeEn_d   = 1'b1;
               writeSel_d  = addr_q;
               writeData_d = DATA_IN;
               addr_d      = addr_q + ADDR_W'(1);
               remaining_d = remaining_q - (ADDR_W + 1)'(1);
               if (remaining_q == (ADDR_W + 1)'(1)) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      busy_d    = (state_d != IDLE);
      cpuHalt_d = (state_d == LOAD) || (state_d == FLUSH);
   end

   // Reset drops any pending write immediately; the file reloads BIOS itself
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q     <= BOOT;
         addr_q      <= '0;
         remaining_q <= '0;
         writeEn_q   <= 1'b0;
         writeSel_q  <= '0;
         writeData_q <= '0;
         cpuHalt_q   <= 1'b0;
         busy_q      <= 1'b1;
         cmdError_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         writeEn_q   <= writeEn_d;
         writeSel_q  <= writeSel_d;
         writeData_q <= writeData_d;
         cpuHalt_q   <= cpuHalt_d;
         busy_q      <= busy_d;
         cmdError_q  <= cmdError_d;
      end
   end

   assign WRITE_ENABLE = writeEn_q;
   assign WRITE_SELECT = writeSel_q;
   assign IMEM_INPUT   = writeData_q;
   assign CPU_HALT     = cpuHalt_q;
   assign BUSY         = busy_q;
   assign CMD_ERROR    = cmdError_q;

   imem_read_arbiter uReadArbiter (
      .cpuRun_i  (CPU_RUN),
      .isIdle_i  (state_q == IDLE),
      .dbgReq_i  (DBG_READ_REQ),
      .dbgAddr_i (DBG_READ_ADDR),
      .pcAddr_i  (PC_ADDR),
      .grant_o   (DBG_READ_GRANT),
      .readSel_o (READ_SELECT)
   );

endmodule

// File: tb/tb_imem_low_load_controller.sv
// Self-checking bench for the instruction-memory load controller: randomized
// bursts scored against a word-count/slot model, plus reset and arbitration cases.
module tb_imem_low_load_controller;

   logic        CLOCK;
   logic        RESET;
   logic        START;
   logic [3:0]  BASE_ADDR;
   logic [4:0]  WORD_COUNT;
   logic [15:0] DATA_IN;
   logic        DATA_VALID;
   logic        DATA_READY;
   logic        WRITE_ENABLE;
   logic [3:0]  WRITE_SELECT;
   logic [15:0] IMEM_INPUT;
   logic        CPU_RUN;
   logic [3:0]  PC_ADDR;
   logic        DBG_READ_REQ;
   logic [3:0]  DBG_READ_ADDR;
   logic        DBG_READ_GRANT;
   logic [3:0]  READ_SELECT;
   logic        CPU_HALT;
   logic        BUSY;
   logic        DONE;
   logic        CMD_ERROR;

   int checks = 0;
   int fails  = 0;

   imem_low_load_controller dut (
      .CLOCK          (CLOCK),
      .RESET          (RESET),
      .START          (START),
      .BASE_ADDR      (BASE_ADDR),
      .WORD_COUNT     (WORD_COUNT),
      .DATA_IN        (DATA_IN),
      .DATA_VALID     (DATA_VALID),
      .DATA_READY     (DATA_READY),
      .WRITE_ENABLE   (WRITE_ENABLE),
      .WRITE_SELECT   (WRITE_SELECT),
      .IMEM_INPUT     (IMEM_INPUT),
      .CPU_RUN        (CPU_RUN),
      .PC_ADDR        (PC_ADDR),
      .DBG_READ_REQ   (DBG_READ_REQ),
      .DBG_READ_ADDR  (DBG_READ_ADDR),
      .DBG_READ_GRANT (DBG_READ_GRANT),
      .READ_SELECT    (READ_SELECT),
      .CPU_HALT       (CPU_HALT),
      .BUSY           (BUSY),
      .DONE           (DONE),
      .CMD_ERROR      (CMD_ERROR)
   );

   // Free-running clock; outputs are sampled on the falling edge
   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   task automatic test_reset();
      RESET = 1'b1; START = 1'b1; BASE_ADDR = 4'd5; WORD_COUNT = 5'd3;
      DATA_VALID = 1'b1; DATA_IN = 16'h1234;
      CPU_RUN = 1'b0; PC_ADDR = 4'd0; DBG_READ_REQ = 1'b1; DBG_READ_ADDR = 4'd7;
      repeat (2) @(negedge CLOCK);
      checks++;
      if (WRITE_ENABLE !== 1'b0 || WRITE_SELECT !== 4'd0 || IMEM_INPUT !== 16'd0) begin
         fails++;
         $display("[TB] FAIL reset_write: we=%b sel=%0d data=%h, required 0/0/0000", WRITE_ENABLE, WRITE_SELECT, IMEM_INPUT);
      end
      checks++;
      if (BUSY !== 1'b1 || CPU_HALT !== 1'b0 || DONE !== 1'b0 || CMD_ERROR !== 1'b0 || DATA_READY !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_status: busy=%b halt=%b done=%b err=%b rdy=%b, required 1/0/0/0/0", BUSY, CPU_HALT, DONE, CMD_ERROR, DATA_READY);
      end
      checks++;
      if (DBG_READ_GRANT !== 1'b0 || READ_SELECT !== 4'd0) begin
         fails++;
         $display("[TB] FAIL reset_grant: grant=%b rsel=%0d, required 0/0", DBG_READ_GRANT, READ_SELECT);
      end
      RESET = 1'b0;
      #1;
      checks++;
      if (BUSY !== 1'b1 || WRITE_ENABLE !== 1'b0 || DATA_READY !== 1'b0) begin
         fails++;
         $display("[TB] FAIL boot_cycle: busy=%b we=%b rdy=%b, required 1/0/0", BUSY, WRITE_ENABLE, DATA_READY);
      end
      @(negedge CLOCK);
      checks++;
      if (BUSY !== 1'b0 || CPU_HALT !== 1'b0 || WRITE_ENABLE !== 1'b0 || DATA_READY !== 1'b0) begin
         fails++;
         $display("[TB] FAIL boot_to_idle: busy=%b halt=%b we=%b rdy=%b, required 0/0/0/0", BUSY, CPU_HALT, WRITE_ENABLE, DATA_READY);
      end
      checks++;
      if (DBG_READ_GRANT !== 1'b1 || READ_SELECT !== 4'd7) begin
         fails++;
         $display("[TB] FAIL idle_grant: grant=%b rsel=%0d, required 1/7", DBG_READ_GRANT, READ_SELECT);
      end
      START = 1'b0; DATA_VALID = 1'b0; DBG_READ_REQ = 1'b0;
      @(negedge CLOCK);
      checks++;
      if (BUSY !== 1'b0 || WRITE_ENABLE !== 1'b0) begin
         fails++;
         $display("[TB] FAIL boot_start_ignored: busy=%b we=%b, required 0/0", BUSY, WRITE_ENABLE);
      end
   endtask

   // Reference model: the k-th accepted word lands in slot (base+k) mod 16 one
   // cycle after its handshake; the write of word #count carries DONE.
   task automatic run_load(input logic [3:0] base, input int count, input int validMode, input bit seqData);
      int          accepted;
      int          cyc;
      bit          pend;
      bit          finished;
      logic [3:0]  pSlot;
      logic [15:0] pData;
      logic [15:0] w;
      bit          vld;
      @(negedge CLOCK);
      START = 1'b1; BASE_ADDR = base; WORD_COUNT = 5'(count); DATA_VALID = 1'b0;
      @(negedge CLOCK);
      START = 1'b0;
      accepted = 0; cyc = 0; pend = 1'b0; finished = 1'b0;
      while (!finished) begin
         checks++;
         if (WRITE_ENABLE !== pend) begin
            fails++;
            $display("[TB] FAIL load_we: cycle %0d we=%b, required %b", cyc, WRITE_ENABLE, pend);
         end
         if (pend) begin
            checks++;
            if (WRITE_SELECT !== pSlot || IMEM_INPUT !== pData) begin
               fails++;
               $display("[TB] FAIL load_write: sel=%0d data=%h, required %0d/%h", WRITE_SELECT, IMEM_INPUT, pSlot, pData);
            end
         end
         checks++;
         if (DONE !== (pend && accepted == count) || DATA_READY !== (accepted < count)) begin
            fails++;
            $display("[TB] FAIL load_done_ready: done=%b rdy=%b, required %b/%b", DONE, DATA_READY, pend && accepted == count, accepted < count);
         end
         checks++;
         if (CPU_HALT !== 1'b1 || BUSY !== 1'b1 || DBG_READ_GRANT !== 1'b0 || READ_SELECT !== PC_ADDR) begin
            fails++;
            $display("[TB] FAIL load_status: halt=%b busy=%b grant=%b rsel=%0d, required 1/1/0/%0d", CPU_HALT, BUSY, DBG_READ_GRANT, READ_SELECT, PC_ADDR);
         end
         if (pend && accepted == count) begin
            finished = 1'b1;
         end else if (cyc > 300) begin
            fails++;
            $display("[TB] FAIL load_timeout: accepted %0d of %0d words", accepted, count);
            finished = 1'b1;
         end else begin
            case (validMode)
               0:       vld = 1'b1;
               1:       vld = (cyc % 2 == 0);
               default: vld = ($urandom_range(0, 2) != 0);
            endcase
            w = seqData ? 16'hA001 + 16'(accepted) : 16'($urandom);
            DATA_VALID = vld; DATA_IN = w;
            START = (validMode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            BASE_ADDR = 4'($urandom); WORD_COUNT = 5'($urandom_range(1, 16));
            DBG_READ_REQ = 1'($urandom); DBG_READ_ADDR = 4'($urandom);
            PC_ADDR = 4'($urandom); CPU_RUN = 1'($urandom);
            if (vld && accepted < count) begin
               pend = 1'b1;
               pSlot = 4'((int'(base) + accepted) % 16);
               pData = w;
               accepted++;
            end else begin
               pend = 1'b0;
            end
            cyc++;
            @(negedge CLOCK);
         end
      end
      // A START coincident with FLUSH must not launch another load
      START = 1'b1; BASE_ADDR = 4'($urandom); WORD_COUNT = 5'd2;
      DATA_VALID = 1'b1; DBG_READ_REQ = 1'b0;
      @(negedge CLOCK);
      checks++;
      if (BUSY !== 1'b0 || CPU_HALT !== 1'b0 || WRITE_ENABLE !== 1'b0 || DONE !== 1'b0 || DATA_READY !== 1'b0) begin
         fails++;
         $display("[TB] FAIL post_flush_idle: busy=%b halt=%b we=%b done=%b rdy=%b, required all 0", BUSY, CPU_HALT, WRITE_ENABLE, DONE, DATA_READY);
      end
      START = 1'b0; DATA_VALID = 1'b0;
   endtask

   task automatic test_basic();
      run_load(4'd0, 3, 0, 1'b1);
   endtask

   task automatic test_wrap();
      run_load(4'd14, 4, 1, 1'b0);
   endtask

   task automatic test_full_depth();
      run_load(4'($urandom), 16, 2, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         run_load(4'($urandom), $urandom_range(1, 16), $urandom_range(0, 2), 1'b0);
      end
   endtask

   task automatic test_illegal();
      logic [4:0] bad [3];
      bad[0] = 5'd0; bad[1] = 5'd17; bad[2] = 5'($urandom_range(18, 31));
      for (int i = 0; i < 3; i++) begin
         @(negedge CLOCK);
         START = 1'b1; WORD_COUNT = bad[i]; BASE_ADDR = 4'($urandom); DATA_VALID = 1'b1;
         @(negedge CLOCK);
         START = 1'b0;
         checks++;
         if (CMD_ERROR !== 1'b1 || BUSY !== 1'b0 || WRITE_ENABLE !== 1'b0 || DATA_READY !== 1'b0) begin
            fails++;
            $display("[TB] FAIL illegal_pulse: count=%0d err=%b busy=%b we=%b rdy=%b, required 1/0/0/0", bad[i], CMD_ERROR, BUSY, WRITE_ENABLE, DATA_READY);
         end
         @(negedge CLOCK);
         checks++;
         if (CMD_ERROR !== 1'b0 || BUSY !== 1'b0 || WRITE_ENABLE !== 1'b0) begin
            fails++;
            $display("[TB] FAIL illegal_after: count=%0d err=%b busy=%b we=%b, required 0/0/0", bad[i], CMD_ERROR, BUSY, WRITE_ENABLE);
         end
         DATA_VALID = 1'b0;
      end
   endtask

   task automatic test_reset_midload();
      logic [3:0] base;
      base = 4'($urandom);
      @(negedge CLOCK);
      START = 1'b1; BASE_ADDR = base; WORD_COUNT = 5'd5;
      @(negedge CLOCK);
      START = 1'b0; DATA_VALID = 1'b1; DATA_IN = 16'hB001;
      @(negedge CLOCK);
      DATA_IN = 16'hB002;
      @(negedge CLOCK);
      checks++;
      if (WRITE_ENABLE !== 1'b1 || WRITE_SELECT !== 4'(base + 4'd1) || IMEM_INPUT !== 16'hB002) begin
         fails++;
         $display("[TB] FAIL midload_second: we=%b sel=%0d data=%h, required 1/%0d/B002", WRITE_ENABLE, WRITE_SELECT, IMEM_INPUT, 4'(base + 4'd1));
      end
      DATA_IN = 16'hB003;
      #2 RESET = 1'b1;
      #1;
      checks++;
      if (WRITE_ENABLE !== 1'b0 || WRITE_SELECT !== 4'd0 || IMEM_INPUT !== 16'd0 || BUSY !== 1'b1 ||
          CPU_HALT !== 1'b0 || DATA_READY !== 1'b0 || DONE !== 1'b0) begin
         fails++;
         $display("[TB] FAIL midload_reset: we=%b sel=%0d data=%h busy=%b halt=%b rdy=%b done=%b, required 0/0/0000/1/0/0/0",
                  WRITE_ENABLE, WRITE_SELECT, IMEM_INPUT, BUSY, CPU_HALT, DATA_READY, DONE);
      end
      @(negedge CLOCK);
      RESET = 1'b0;
      #1;
      checks++;
      if (BUSY !== 1'b1 || WRITE_ENABLE !== 1'b0 || DATA_READY !== 1'b0) begin
         fails++;
         $display("[TB] FAIL midload_boot: busy=%b we=%b rdy=%b, required 1/0/0", BUSY, WRITE_ENABLE, DATA_READY);
      end
      @(negedge CLOCK);
      checks++;
      if (BUSY !== 1'b0 || WRITE_ENABLE !== 1'b0 || CPU_HALT !== 1'b0) begin
         fails++;
         $display("[TB] FAIL midload_idle: busy=%b we=%b halt=%b, required 0/0/0", BUSY, WRITE_ENABLE, CPU_HALT);
      end
      DATA_VALID = 1'b0;
   endtask

   task automatic test_arbiter();
      logic expGrant;
      logic [3:0] expSel;
      @(negedge CLOCK);
      DBG_READ_REQ = 1'b1; DBG_READ_ADDR = 4'd9; PC_ADDR = 4'd3; CPU_RUN = 1'b0;
      #1;
      checks++;
      if (DBG_READ_GRANT !== 1'b1 || READ_SELECT !== 4'd9) begin
         fails++;
         $display("[TB] FAIL arb_idle: grant=%b rsel=%0d, required 1/9", DBG_READ_GRANT, READ_SELECT);
      end
      CPU_RUN = 1'b1;
      #1;
      checks++;
      if (DBG_READ_GRANT !== 1'b0 || READ_SELECT !== 4'd3) begin
         fails++;
         $display("[TB] FAIL arb_cpu_run: grant=%b rsel=%0d, required 0/3", DBG_READ_GRANT, READ_SELECT);
      end
      CPU_RUN = 1'b0;
      @(negedge CLOCK);
      START = 1'b1; BASE_ADDR = 4'd2; WORD_COUNT = 5'd1;
      @(negedge CLOCK);
      START = 1'b0;
      checks++;
      if (DBG_READ_GRANT !== 1'b0 || READ_SELECT !== 4'd3) begin
         fails++;
         $display("[TB] FAIL arb_load: grant=%b rsel=%0d, required 0/3", DBG_READ_GRANT, READ_SELECT);
      end
      DATA_VALID = 1'b1; DATA_IN = 16'hC0DE;
      @(negedge CLOCK);
      DATA_VALID = 1'b0;
      checks++;
      if (WRITE_ENABLE !== 1'b1 || DONE !== 1'b1 || WRITE_SELECT !== 4'd2 || DBG_READ_GRANT !== 1'b0) begin
         fails++;
         $display("[TB] FAIL arb_flush: we=%b done=%b sel=%0d grant=%b, required 1/1/2/0", WRITE_ENABLE, DONE, WRITE_SELECT, DBG_READ_GRANT);
      end
      @(negedge CLOCK);
      checks++;
      if (DBG_READ_GRANT !== 1'b1 || READ_SELECT !== 4'd9) begin
         fails++;
         $display("[TB] FAIL arb_back_idle: grant=%b rsel=%0d, required 1/9", DBG_READ_GRANT, READ_SELECT);
      end
      for (int i = 0; i < 10; i++) begin
         DBG_READ_REQ = 1'($urandom); CPU_RUN = 1'($urandom);
         DBG_READ_ADDR = 4'($urandom); PC_ADDR = 4'($urandom);
         #1;
         expGrant = DBG_READ_REQ && !CPU_RUN;
         expSel   = expGrant ? DBG_READ_ADDR : PC_ADDR;
         checks++;
         if (DBG_READ_GRANT !== expGrant || READ_SELECT !== expSel) begin
            fails++;
            $display("[TB] FAIL arb_random: grant=%b rsel=%0d, required %b/%0d", DBG_READ_GRANT, READ_SELECT, expGrant, expSel);
         end
      end
      DBG_READ_REQ = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_illegal();
      test_full_depth();
      test_back_to_back();
      test_reset_midload();
      test_arbiter();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
